// File: rtl/generic_demux_pkg.sv
// Shared sizing constants and the select-legality helper for the generic demultiplexer.
package generic_demux_pkg;
    localparam int N_DEF   = 3;
    localparam int W_DEF   = 8;
    localparam int CNT_W   = 8;
    localparam int SEL_MAX = 32;

    // Exactly one bit set; callers zero-extend narrower selects to SEL_MAX.
    function automatic logic is_onehot(input logic [SEL_MAX-1:0] v);
        return (v != {SEL_MAX{1'b0}}) && ((v & (v - 32'd1)) == {SEL_MAX{1'b0}});
    endfunction
endpackage

// File: rtl/generic_demux_if.sv
// Source-side handshake plus the per-channel sink buses of the demultiplexer.
interface generic_demux_if #(
    parameter int N = generic_demux_pkg::N_DEF,
    parameter int W = generic_demux_pkg::W_DEF
) ();
    import generic_demux_pkg::*;

    logic [N-1:0]            io_select;
    logic                    io_in_valid;
    logic                    io_in_ready;
    logic [W-1:0]            io_in_bits;
    logic [N-1:0]            io_outputs_valid;
    logic [N-1:0]            io_outputs_ready;
    logic [N-1:0][W-1:0]     io_outputs_bits;
    logic [N-1:0][CNT_W-1:0] io_outputs_count;
    logic                    io_error;

    modport slave (
        input  io_select, io_in_valid, io_in_bits, io_outputs_ready,
        output io_in_ready, io_outputs_valid, io_outputs_bits, io_outputs_count, io_error
    );

    modport master (
        output io_select, io_in_valid, io_in_bits, io_outputs_ready,
        input  io_in_ready, io_outputs_valid, io_outputs_bits, io_outputs_count, io_error
    );
endinterface

// File: rtl/generic_demux_slot.sv
// One output channel: single-entry buffer and a wrapping count of completed drains.
module demux_slot
    import generic_demux_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [W-1:0]     in_bits,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [W-1:0]     out_bits,
    output logic [CNT_W-1:0] out_count
);
    logic             full_q,  full_d;
    logic [W-1:0]     data_q,  data_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             drain_s;

    // Next-state: a load wins over a drain so a same-cycle refill leaves no bubble.
    always_comb begin
        drain_s = full_q & out_ready;
        full_d  = full_q;
        data_d  = data_q;
        count_d = count_q;
        if (load) begin
            full_d = 1'b1;
            data_d = in_bits;
        end else if (drain_s) begin
            full_d = 1'b0;
        end else begin
            full_d = full_q;
        end
        if (drain_s) begin
            count_d = count_q + 8'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Buffer and counter state with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            full_q  <= 1'b0;
            data_q  <= {W{1'b0}};
            count_q <= {CNT_W{1'b0}};
        end else begin
            full_q  <= full_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign out_valid = full_q;
    assign out_bits  = data_q;
    assign out_count = count_q;
endmodule

// File: rtl/generic_demux.sv
// Demultiplexer top: select decode, ready mux and sticky error; N buffered channels below.
module generic_demux
    import generic_demux_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic            clock,
    input  logic            reset,
    generic_demux_if.slave  io
);
    logic                    sel_legal_s;
    logic                    sel_ready_s;
    logic                    in_ready_s;
    logic [N-1:0]            load_s;
    logic [N-1:0]            valid_s;
    logic [N-1:0][W-1:0]     bits_s;
    logic [N-1:0][CNT_W-1:0] count_s;
    logic                    error_q, error_d;

    // Select decode and ready mux; with a legal one-hot select the AND-OR is the mux.
    always_comb begin
        sel_legal_s = is_onehot(SEL_MAX'(io.io_select));
        sel_ready_s = |(io.io_select & (~valid_s | io.io_outputs_ready));
        in_ready_s  = sel_legal_s & sel_ready_s;
        load_s      = {N{1'b0}};
        if (io.io_in_valid && in_ready_s) begin
            load_s = io.io_select;
        end else begin
            load_s = {N{1'b0}};
        end
        error_d = error_q | (io.io_in_valid & ~sel_legal_s);
    end

    // Sticky illegal-select flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_slot
        demux_slot #(.W(W)) u_slot (
            .clock     (clock),
            .reset     (reset),
            .load      (load_s[i]),
            .in_bits   (io.io_in_bits),
            .out_ready (io.io_outputs_ready[i]),
            .out_valid (valid_s[i]),
            .out_bits  (bits_s[i]),
            .out_count (count_s[i])
        );
    end

    assign io.io_in_ready      = in_ready_s;
    assign io.io_outputs_valid = valid_s;
    assign io.io_outputs_bits  = bits_s;
    assign io.io_outputs_count = count_s;
    assign io.io_error         = error_q;
endmodule

// File: tb/tb_generic_demux.sv
// Directed self-checking bench for generic_demux with N=3, W=8.
module tb_generic_demux;
    logic clock;
    logic reset;
    int   check_cnt;
    int   error_cnt;

    generic_demux_if #(.N(3), .W(8)) dif ();

    generic_demux #(.N(3), .W(8)) dut (
        .clock (clock),
        .reset (reset),
        .io    (dif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            error_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [2:0] sel, input logic vld, input logic [7:0] data);
        dif.io_select   = sel;
        dif.io_in_valid = vld;
        dif.io_in_bits  = data;
    endtask

    initial begin
        check_cnt = 0;
        error_cnt = 0;
        reset = 1'b1;
        dif.io_outputs_ready = 3'b000;
        drive(3'b000, 1'b0, 8'h00);
        tick();
        tick();
        reset = 1'b0;
        #1;
        check_val("rst_valid", 32'(dif.io_outputs_valid), 32'h0);
        check_val("rst_count0", 32'(dif.io_outputs_count[0]), 32'h0);
        check_val("rst_error", 32'(dif.io_error), 32'h0);
        check_val("rst_rdy_sel0", 32'(dif.io_in_ready), 32'h0);
        drive(3'b001, 1'b0, 8'h00);
        #1;
        check_val("rst_rdy_sel1", 32'(dif.io_in_ready), 32'h1);

        // Basic transfer with one-cycle latency.
        dif.io_outputs_ready = 3'b001;
        drive(3'b001, 1'b1, 8'hA5);
        #1;
        check_val("t1_no_comb_path", 32'(dif.io_outputs_valid), 32'h0);
        tick();
        drive(3'b001, 1'b0, 8'h00);
        check_val("t1_valid", 32'(dif.io_outputs_valid), 32'h1);
        check_val("t1_bits", 32'(dif.io_outputs_bits[0]), 32'hA5);
        tick();
        check_val("t1_drained", 32'(dif.io_outputs_valid), 32'h0);
        check_val("t1_count0", 32'(dif.io_outputs_count[0]), 32'h1);

        // Stalled channel 1 must not block channel 2.
        dif.io_outputs_ready = 3'b000;
        drive(3'b010, 1'b1, 8'h11);
        tick();
        drive(3'b010, 1'b0, 8'h00);
        #1;
        check_val("t2_stall_rdy", 32'(dif.io_in_ready), 32'h0);
        drive(3'b100, 1'b1, 8'h22);
        #1;
        check_val("t2_other_rdy", 32'(dif.io_in_ready), 32'h1);
        tick();
        drive(3'b100, 1'b0, 8'h00);
        check_val("t2_valid", 32'(dif.io_outputs_valid), 32'h6);
        check_val("t2_bits2", 32'(dif.io_outputs_bits[2]), 32'h22);
        check_val("t2_bits1", 32'(dif.io_outputs_bits[1]), 32'h11);
        dif.io_outputs_ready = 3'b110;
        tick();
        check_val("t2_drained", 32'(dif.io_outputs_valid), 32'h0);
        check_val("t2_count1", 32'(dif.io_outputs_count[1]), 32'h1);
        check_val("t2_count2", 32'(dif.io_outputs_count[2]), 32'h1);

        // Same-cycle drain and refill on channel 0.
        dif.io_outputs_ready = 3'b000;
        drive(3'b001, 1'b1, 8'h44);
        tick();
        check_val("t3_full", 32'(dif.io_outputs_bits[0]), 32'h44);
        dif.io_outputs_ready = 3'b001;
        drive(3'b001, 1'b1, 8'h33);
        #1;
        check_val("t3_rdy_full", 32'(dif.io_in_ready), 32'h1);
        tick();
        drive(3'b001, 1'b0, 8'h00);
        check_val("t3_valid", 32'(dif.io_outputs_valid), 32'h1);
        check_val("t3_bits", 32'(dif.io_outputs_bits[0]), 32'h33);
        check_val("t3_count0", 32'(dif.io_outputs_count[0]), 32'h2);
        tick();
        check_val("t3_drained", 32'(dif.io_outputs_valid), 32'h0);
        check_val("t3_count0b", 32'(dif.io_outputs_count[0]), 32'h3);

        // Illegal selects: zero without valid is harmless, multi-hot with valid is sticky.
        dif.io_outputs_ready = 3'b000;
        drive(3'b000, 1'b0, 8'h00);
        #1;
        check_val("t4_rdy_zero", 32'(dif.io_in_ready), 32'h0);
        tick();
        check_val("t4_no_err", 32'(dif.io_error), 32'h0);
        drive(3'b011, 1'b1, 8'h55);
        #1;
        check_val("t4_rdy_multi", 32'(dif.io_in_ready), 32'h0);
        check_val("t4_err_not_yet", 32'(dif.io_error), 32'h0);
        tick();
        drive(3'b001, 1'b0, 8'h00);
        check_val("t4_err_set", 32'(dif.io_error), 32'h1);
        check_val("t4_no_load", 32'(dif.io_outputs_valid), 32'h0);
        tick();
        tick();
        check_val("t4_err_sticky", 32'(dif.io_error), 32'h1);

        // Streaming on channel 2: 254 drains take count_2 from 1 to 255, one more wraps.
        dif.io_outputs_ready = 3'b100;
        for (int i = 0; i < 254; i++) begin
            drive(3'b100, 1'b1, 8'(i));
            tick();
        end
        drive(3'b100, 1'b0, 8'h00);
        check_val("t5_last_bits", 32'(dif.io_outputs_bits[2]), 32'hFD);
        tick();
        check_val("t5_count255", 32'(dif.io_outputs_count[2]), 32'hFF);
        drive(3'b100, 1'b1, 8'h77);
        tick();
        drive(3'b100, 1'b0, 8'h00);
        tick();
        check_val("t5_wrap", 32'(dif.io_outputs_count[2]), 32'h0);

        // Reset with all buffers full.
        dif.io_outputs_ready = 3'b000;
        drive(3'b001, 1'b1, 8'h01);
        tick();
        drive(3'b010, 1'b1, 8'h02);
        tick();
        drive(3'b100, 1'b1, 8'h03);
        tick();
        drive(3'b100, 1'b0, 8'h00);
        check_val("t6_all_full", 32'(dif.io_outputs_valid), 32'h7);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("t6_valid", 32'(dif.io_outputs_valid), 32'h0);
        check_val("t6_count0", 32'(dif.io_outputs_count[0]), 32'h0);
        check_val("t6_count1", 32'(dif.io_outputs_count[1]), 32'h0);
        check_val("t6_bits2", 32'(dif.io_outputs_bits[2]), 32'h0);
        check_val("t6_error", 32'(dif.io_error), 32'h0);
        check_val("t6_rdy", 32'(dif.io_in_ready), 32'h1);

        $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
        $finish;
    end
endmodule
